// File: rtl/cache_ctrl_pkg.sv
// Shared MESI encodings and sizing helpers for the L1 cache controllers.
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_t;

    localparam int unsigned DEF_ASSOC    = 4;
    localparam int unsigned DEF_NUM_SETS = 64;

    function automatic int unsigned way_w(input int unsigned assoc);
        return (assoc > 1) ? $clog2(assoc) : 1;
    endfunction

    function automatic int unsigned index_w(input int unsigned num_sets);
        return (num_sets > 1) ? $clog2(num_sets) : 1;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree pseudo-LRU: victim walk and access update for one set.
module plru_tree
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned ASSOC = DEF_ASSOC,
    parameter int unsigned WAY_W = way_w(ASSOC)
) (
    input  logic [ASSOC-2:0] bits_i,
    input  logic [WAY_W-1:0] way_i,
    output logic [WAY_W-1:0] victim_o,
    output logic [ASSOC-2:0] next_bits_o
);

    localparam int unsigned LEVELS = $clog2(ASSOC);

    // Heap walk: a 0 bit sends the victim search to the left child.
    always_comb begin : victim_walk
        int unsigned node;
        logic [ASSOC-2:0] sh;
        node = 0;
        sh   = '0;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            sh   = bits_i >> node;
            node = 2 * node + 1 + 32'(sh[0]);
        end
        victim_o = WAY_W'(node - (ASSOC - 1));
    end

    // Climb from the accessed leaf; odd heap positions are left children.
    always_comb begin : touch_walk
        int unsigned pos;
        int unsigned parent;
        logic [ASSOC-2:0] one;
        one         = '0;
        one[0]      = 1'b1;
        next_bits_o = bits_i;
        pos         = 32'(way_i) + ASSOC - 1;
        parent      = 0;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            parent = (pos - 1) >> 1;
            if (pos[0]) begin
                next_bits_o = next_bits_o | (one << parent);
            end else begin
                next_bits_o = next_bits_o & ~(one << parent);
            end
            pos = parent;
        end
    end

endmodule

// File: rtl/mesi_plru_ctrl.sv
// Registered MESI controller with per-set tree PLRU; one processor request or snoop per cycle.
module mesi_plru_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned ASSOC    = DEF_ASSOC,
    parameter int unsigned NUM_SETS = DEF_NUM_SETS,
    parameter int unsigned WAY_W    = way_w(ASSOC),
    parameter int unsigned INDEX_W  = index_w(NUM_SETS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               PrRd,
    input  logic               PrWr,
    input  logic [INDEX_W-1:0] Index_proc,
    input  logic               Hit_proc,
    input  logic [WAY_W-1:0]   Way_hit_proc,
    input  logic [1:0]         Current_MESI_state_proc,
    input  logic [ASSOC-1:0]   Way_valid,
    input  logic [ASSOC-1:0]   Way_modified,
    input  logic               Shared,
    input  logic               BusRd,
    input  logic               BusRdX,
    input  logic               Invalidate,
    input  logic               Hit_snoop,
    input  logic [1:0]         Current_MESI_state_snoop,
    output logic               Proc_ready,
    output logic               Proc_done,
    output logic [1:0]         Updated_MESI_state_proc,
    output logic [WAY_W-1:0]   Proc_way,
    output logic               Issue_BusRd,
    output logic               Issue_BusRdX,
    output logic               Issue_Invalidate,
    output logic               Writeback_req,
    output logic               Snoop_done,
    output logic [1:0]         Updated_MESI_state_snoop,
    output logic               Flush,
    output logic               Protocol_err
);

    logic [ASSOC-2:0] lru_q [NUM_SETS];

    logic             snoop_req, proc_acc;
    logic [ASSOC-2:0] set_bits, set_bits_next;
    logic [WAY_W-1:0] plru_victim, inv_way, way_sel;
    logic             any_inv, wb_sel;
    mesi_t            cur_proc, cur_snoop, proc_st, snoop_st;
    logic             brd, brdx, inval, flush_sel, err_sel;

    logic             proc_done_q, wb_q, snoop_done_q, flush_q, err_q;
    logic             brd_q, brdx_q, inval_q;
    mesi_t            proc_st_q, snoop_st_q;
    logic [WAY_W-1:0] way_q;

    assign snoop_req  = BusRd | BusRdX | Invalidate;
    assign Proc_ready = ~snoop_req;
    assign proc_acc   = Proc_ready & (PrRd | PrWr);
    assign set_bits   = lru_q[Index_proc];

    plru_tree #(
        .ASSOC (ASSOC),
        .WAY_W (WAY_W)
    ) u_plru_tree (
        .bits_i      (set_bits),
        .way_i       (way_sel),
        .victim_o    (plru_victim),
        .next_bits_o (set_bits_next)
    );

    always_comb begin
        logic [ASSOC-1:0] vld_sh;
        any_inv = 1'b0;
        inv_way = '0;
        vld_sh  = '0;
        for (int unsigned w = 0; w < ASSOC; w++) begin
            vld_sh = Way_valid >> w;
            if (!vld_sh[0] && !any_inv) begin
                any_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign way_sel = Hit_proc ? Way_hit_proc : (any_inv ? inv_way : plru_victim);
    assign wb_sel  = ~Hit_proc & ~any_inv & Way_modified[plru_victim];

    always_comb begin
        cur_proc = mesi_t'(Current_MESI_state_proc);
        proc_st  = MESI_M;
        brd      = 1'b0;
        brdx     = 1'b0;
        inval    = 1'b0;
        if (Hit_proc && cur_proc != MESI_I) begin
            case (cur_proc)
                MESI_E: proc_st = PrWr ? MESI_M : MESI_E;
                MESI_S: begin
                    proc_st = PrWr ? MESI_M : MESI_S;
                    inval   = PrWr;
                end
                default: proc_st = MESI_M;
            endcase
        end else if (PrWr) begin
            brdx = 1'b1;
        end else begin
            proc_st = Shared ? MESI_S : MESI_E;
            brd     = 1'b1;
        end
    end

    // Invalidate on an exclusive owner is illegal: keep the state, flag it.
    always_comb begin
        cur_snoop = mesi_t'(Current_MESI_state_snoop);
        snoop_st  = MESI_I;
        flush_sel = 1'b0;
        err_sel   = 1'b0;
        if (Hit_snoop) begin
            case (cur_snoop)
                MESI_M, MESI_E: begin
                    if (BusRd) begin
                        snoop_st = MESI_S;
                    end else if (Invalidate && !BusRdX) begin
                        snoop_st = cur_snoop;
                        err_sel  = 1'b1;
                    end
                    flush_sel = (cur_snoop == MESI_M) & (BusRd | BusRdX);
                end
                MESI_S:  snoop_st = (BusRdX | Invalidate) ? MESI_I : MESI_S;
                default: snoop_st = MESI_I;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_SETS; i++) begin
                lru_q[i] <= '0;
            end
        end else if (proc_acc) begin
            lru_q[Index_proc] <= set_bits_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proc_done_q  <= 1'b0;
            proc_st_q    <= MESI_I;
            way_q        <= '0;
            brd_q        <= 1'b0;
            brdx_q       <= 1'b0;
            inval_q      <= 1'b0;
            wb_q         <= 1'b0;
            snoop_done_q <= 1'b0;
            snoop_st_q   <= MESI_I;
            flush_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            proc_done_q  <= proc_acc;
            proc_st_q    <= proc_acc ? proc_st : MESI_I;
            way_q        <= proc_acc ? way_sel : '0;
            brd_q        <= proc_acc & brd;
            brdx_q       <= proc_acc & brdx;
            inval_q      <= proc_acc & inval;
            wb_q         <= proc_acc & wb_sel;
            snoop_done_q <= snoop_req;
            snoop_st_q   <= snoop_req ? snoop_st : MESI_I;
            flush_q      <= snoop_req & flush_sel;
            err_q        <= snoop_req & err_sel;
        end
    end

    assign Proc_done                = proc_done_q;
    assign Updated_MESI_state_proc  = proc_st_q;
    assign Proc_way                 = way_q;
    assign Issue_BusRd              = brd_q;
    assign Issue_BusRdX             = brdx_q;
    assign Issue_Invalidate         = inval_q;
    assign Writeback_req            = wb_q;
    assign Snoop_done               = snoop_done_q;
    assign Updated_MESI_state_snoop = snoop_st_q;
    assign Flush                    = flush_q;
    assign Protocol_err             = err_q;

endmodule
